// File: rtl/alu_pkg.sv
`default_nettype none
// =====================================================================
// alu_pkg : shared widths, buffer depth, flag bit positions, op modes.
// Rev 1.0
// =====================================================================
package alu_pkg;
  localparam int ALU_WIDTH = 16;
  localparam int BUF_DEPTH = 2;
  localparam int NUM_FLAGS = 4;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef logic [NUM_FLAGS-1:0] flags_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } alu_op_e;
endpackage
`default_nettype wire

// File: rtl/alu_result_stage_if.sv
`default_nettype none
// =====================================================================
// alu_result_stage_if : adder-result input and registered-result output.
// Rev 1.0
// =====================================================================
interface alu_result_stage_if #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             M;
  logic             a_msb;
  logic             b_msb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             negative;
  logic             overflow;

  modport master (
    output in_valid, S, cout, M, a_msb, b_msb, out_ready,
    input  in_ready, out_valid, result, carry, zero, negative, overflow
  );

  modport slave (
    input  in_valid, S, cout, M, a_msb, b_msb, out_ready,
    output in_ready, out_valid, result, carry, zero, negative, overflow
  );
endinterface
`default_nettype wire

// File: rtl/alu_flag_gen.sv
`default_nettype none
// =====================================================================
// alu_flag_gen : combinational carry/zero/negative/overflow from adder result.
// Rev 1.0
// =====================================================================
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] S_i,
  input  logic             cout_i,
  input  logic             M_i,
  input  logic             a_msb_i,
  input  logic             b_msb_i,
  output flags_t           flags_o
);
  logic w_sign_flip;

  // b_msb is the pre-inversion sign, so subtract overflows on differing signs.
  assign w_sign_flip = (S_i[WIDTH-1] != a_msb_i);

  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_C] = cout_i;
    flags_o[FLAG_Z] = (S_i == '0);
    flags_o[FLAG_N] = S_i[WIDTH-1];
    if (M_i == OP_SUB) begin
      flags_o[FLAG_V] = (a_msb_i != b_msb_i) && w_sign_flip;
    end else begin
      flags_o[FLAG_V] = (a_msb_i == b_msb_i) && w_sign_flip;
    end
  end
endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// =====================================================================
// alu_result_stage : 2-entry skid buffer registering adder result + flags.
// Optional macro ALU_RESULT_STAT_EN adds saturating ovf_count output. Rev 1.0
// =====================================================================
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  alu_result_stage_if.slave bus
`ifdef ALU_RESULT_STAT_EN
  ,
  output logic [15:0]       ovf_count
`endif
);
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_res_q, head_res_d, tail_res_q, tail_res_d;
  flags_t           head_flg_q, head_flg_d, tail_flg_q, tail_flg_d;
  flags_t           w_flags;
  logic             w_push, w_pop, w_out_valid, w_in_ready;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .S_i     (bus.S),
    .cout_i  (bus.cout),
    .M_i     (bus.M),
    .a_msb_i (bus.a_msb),
    .b_msb_i (bus.b_msb),
    .flags_o (w_flags)
  );

  assign w_out_valid = (count_q != 2'd0);
  assign w_in_ready  = (count_q < 2'(BUF_DEPTH));
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  always_comb begin
    head_res_d = head_res_q;
    head_flg_d = head_flg_q;
    tail_res_d = tail_res_q;
    tail_flg_d = tail_flg_q;
    count_d    = count_q + {1'b0, w_push} - {1'b0, w_pop};
    if (w_pop) begin
      head_res_d = tail_res_q;
      head_flg_d = tail_flg_q;
    end
    // New entry lands in the head when the buffer is (or is about to be) empty.
    if (w_push) begin
      if ((count_q == 2'd0) || ((count_q == 2'd1) && w_pop)) begin
        head_res_d = bus.S;
        head_flg_d = w_flags;
      end else begin
        tail_res_d = bus.S;
        tail_flg_d = w_flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 2'd0;
      head_res_q <= '0;
      head_flg_q <= '0;
      tail_res_q <= '0;
      tail_flg_q <= '0;
    end else begin
      count_q    <= count_d;
      head_res_q <= head_res_d;
      head_flg_q <= head_flg_d;
      tail_res_q <= tail_res_d;
      tail_flg_q <= tail_flg_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.result    = w_out_valid ? head_res_q : '0;
  assign bus.carry     = w_out_valid && head_flg_q[FLAG_C];
  assign bus.zero      = w_out_valid && head_flg_q[FLAG_Z];
  assign bus.negative  = w_out_valid && head_flg_q[FLAG_N];
  assign bus.overflow  = w_out_valid && head_flg_q[FLAG_V];

`ifdef ALU_RESULT_STAT_EN
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_q <= 16'h0000;
    end else if (w_push && w_flags[FLAG_V] && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 16'h0001;
    end
  end

  assign ovf_count = ovf_cnt_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// =====================================================================
// tb_alu_result_stage : directed self-checking bench for alu_result_stage.
// Rev 1.0
// =====================================================================
module tb_alu_result_stage;
  logic clk;
  logic rst;
  int   tests;
  int   failed;

  alu_result_stage_if #(.WIDTH(16)) bus ();

`ifdef ALU_RESULT_STAT_EN
  logic [15:0] ovf_count;
`endif

  alu_result_stage #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ALU_RESULT_STAT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check full output state; flags packed as {carry, zero, negative, overflow}.
  task automatic check_out(input string tag, input logic ov, input logic ir,
                           input logic [15:0] res, input logic [3:0] flg);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    check({tag, ".in_ready"},  32'(bus.in_ready),  32'(ir));
    check({tag, ".result"},    32'(bus.result),    32'(res));
    check({tag, ".flags"},
          32'({bus.carry, bus.zero, bus.negative, bus.overflow}), 32'(flg));
  endtask

  task automatic drive(input logic v, input logic [15:0] s, input logic c,
                       input logic m, input logic a, input logic b);
    bus.in_valid = v;
    bus.S        = s;
    bus.cout     = c;
    bus.M        = m;
    bus.a_msb    = a;
    bus.b_msb    = b;
  endtask

  // Streaming step with out_ready high: entry visible one cycle later.
  task automatic step(input string tag, input logic [15:0] s, input logic c,
                      input logic m, input logic a, input logic b, input logic [3:0] flg);
    drive(1'b1, s, c, m, a, b);
    @(negedge clk);
    check_out(tag, 1'b1, 1'b1, s, flg);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_out("reset", 1'b0, 1'b1, 16'h0000, 4'b0000);
`ifdef ALU_RESULT_STAT_EN
    check("reset.ovf_count", 32'(ovf_count), 32'd0);
`endif

    step("add",      16'h0014, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    step("sub",      16'h000C, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000);
    step("add_ovf",  16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011);
`ifdef ALU_RESULT_STAT_EN
    check("add_ovf.ovf_count", 32'(ovf_count), 32'd1);
`endif
    step("zero",     16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1100);
    step("add_mix",  16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
    step("sub_ovfp", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0011);
    step("sub_ok",   16'h0005, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
    step("sub_ovfn", 16'h7FFF, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1001);
    step("add_ovfn", 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1001);
`ifdef ALU_RESULT_STAT_EN
    check("stream.ovf_count", 32'(ovf_count), 32'd4);
`endif

    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_out("drain_empty", 1'b0, 1'b1, 16'h0000, 4'b0000);

    // Backpressure: three pushes with out_ready low, third must be dropped.
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_out("bp_push1", 1'b1, 1'b1, 16'h1111, 4'b0000);
    drive(1'b1, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_out("bp_push2", 1'b1, 1'b0, 16'h1111, 4'b0000);
    drive(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_out("bp_push3", 1'b1, 1'b0, 16'h1111, 4'b0000);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_out("bp_pop1", 1'b1, 1'b1, 16'h2222, 4'b1000);
    @(negedge clk);
    check_out("bp_pop2", 1'b0, 1'b1, 16'h0000, 4'b0000);

    // Fill to two entries, then reset while pushing and popping.
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h4444, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 16'h8888, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_out("full", 1'b1, 1'b0, 16'h4444, 4'b0000);
`ifdef ALU_RESULT_STAT_EN
    check("full.ovf_count", 32'(ovf_count), 32'd5);
`endif
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("mid_reset", 1'b0, 1'b1, 16'h0000, 4'b0000);
`ifdef ALU_RESULT_STAT_EN
    check("mid_reset.ovf_count", 32'(ovf_count), 32'd0);
`endif
    @(negedge clk);
    check_out("post_reset", 1'b0, 1'b1, 16'h0000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
`default_nettype wire
